// File: rtl/round_pkg.sv
// Shared types and helpers for the three-player round sequencer.
// State encoding, lane count and the rotating-priority winner picker.
package round_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ARM  = 3'd1,
      PLAY = 3'd2,
      WIN  = 3'd3,
      TOUT = 3'd4
   } state_t;

   localparam int         N_LANES   = 3;
   localparam logic [3:0] SCORE_MAX = 4'hF;

   // First set bit of d scanning upward from p, modulo 3.
   function automatic logic [1:0] pick(
      input logic [2:0] d,
      input logic [1:0] p
   );
      logic [1:0] w;
      case (p)
         2'd1:    w = d[1] ? 2'd1 : (d[2] ? 2'd2 : 2'd0);
         2'd2:    w = d[2] ? 2'd2 : (d[0] ? 2'd0 : 2'd1);
         default: w = d[0] ? 2'd0 : (d[1] ? 2'd1 : 2'd2);
      endcase
      return w;
   endfunction

   function automatic logic [1:0] next_lane(input logic [1:0] w);
      return (w == 2'd2) ? 2'd0 : w + 2'd1;
   endfunction

endpackage

// File: rtl/round_ctrl_if.sv
// Lane control, winner/score and display-scan bundle of the round sequencer.
// master drives go/done; slave is the sequencer.
interface round_ctrl_if;
   import round_pkg::*;

   logic       go;
   logic [2:0] done;
   logic [2:0] start;
   logic [2:0] stop;
   logic [2:0] lane_clr;
   logic [1:0] winner;
   logic       winner_vld;
   logic       timeout;
   logic [3:0] score0;
   logic [3:0] score1;
   logic [3:0] score2;
   logic [1:0] scan_sel;
   logic [3:0] an;

   modport master (
      output go, done,
      input  start, stop, lane_clr, winner, winner_vld, timeout,
      input  score0, score1, score2, scan_sel, an
   );

   modport slave (
      input  go, done,
      output start, stop, lane_clr, winner, winner_vld, timeout,
      output score0, score1, score2, scan_sel, an
   );

endinterface

// File: rtl/round_ctrl_scan_tick.sv
// Display scan prescaler: steps the digit slot 0->1->2 every SCAN_DIV
// cycles and drives the matching active-low anode.
module scan_tick #(
   parameter logic [15:0] SCAN_DIV = 16'd50_000
) (
   input  logic       clock,
   input  logic       reset,
   output logic [1:0] scan_sel,
   output logic [3:0] an
);

   logic [15:0] div;
   logic [1:0]  sel_n;
   logic [3:0]  one;

   assign sel_n = (scan_sel == 2'd2) ? 2'd0 : scan_sel + 2'd1;
   assign one   = 4'b0001;

   always_ff @(posedge clock) begin
      if (reset) begin
         div      <= '0;
         scan_sel <= 2'd0;
         an       <= 4'b1110;
      end else if (div == SCAN_DIV - 16'd1) begin
         div      <= '0;
         scan_sel <= sel_n;
         an       <= ~(one << sel_n);
      end else begin
         div      <= div + 16'd1;
      end
   end

endmodule

// File: rtl/round_ctrl.sv
// Round sequencer: arms, runs and freezes the three press-counter lanes,
// picks the winner with rotating priority and keeps saturating scores.
module round_ctrl
   import round_pkg::*;
#(
   parameter logic [15:0] ARM_CYCLES = 16'd1000,
   parameter logic [31:0] TIMEOUT    = 32'd500_000_000,
   parameter logic [15:0] SCAN_DIV   = 16'd50_000
) (
   input  logic       clock,
   input  logic       reset,
   round_ctrl_if.slave bus
);

   state_t      state;
   state_t      state_n;
   logic [31:0] timer;
   logic [2:0]  done_q;
   logic [1:0]  rr_ptr;
   logic [1:0]  pick_w;
   logic        win_entry;
   logic [3:0]  score [N_LANES];

   logic [2:0]  start_n;
   logic [2:0]  stop_n;
   logic [2:0]  clr_n;
   logic        vld_n;
   logic        tout_n;

   always_comb begin
      state_n = state;
      pick_w  = pick(done_q, rr_ptr);
      unique case (state)
         IDLE: if (bus.go) state_n = ARM;
         ARM:
            if (timer == {16'd0, ARM_CYCLES - 16'd1})
               state_n = PLAY;
         PLAY:
            // A finished lane beats a timeout landing on the same cycle.
            if (done_q != 3'b000)
               state_n = WIN;
            else if (timer == TIMEOUT - 32'd1)
               state_n = TOUT;
         WIN:  if (bus.go) state_n = ARM;
         TOUT: if (bus.go) state_n = ARM;
         default: state_n = IDLE;
      endcase
   end

   assign win_entry = (state == PLAY) && (state_n == WIN);

   always_comb begin
      start_n = 3'b000;
      stop_n  = 3'b000;
      clr_n   = 3'b111;
      vld_n   = 1'b0;
      tout_n  = 1'b0;
      unique case (1'b1)
         state_n == PLAY: begin
            start_n = 3'b111;
            clr_n   = 3'b000;
         end
         state_n == WIN: begin
            start_n = 3'b111;
            stop_n  = 3'b111;
            clr_n   = 3'b000;
            vld_n   = 1'b1;
         end
         state_n == TOUT: begin
            start_n = 3'b111;
            stop_n  = 3'b111;
            clr_n   = 3'b000;
            tout_n  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= IDLE;
         timer          <= '0;
         done_q         <= '0;
         rr_ptr         <= 2'd0;
         bus.start      <= 3'b000;
         bus.stop       <= 3'b000;
         bus.lane_clr   <= 3'b111;
         bus.winner     <= 2'd0;
         bus.winner_vld <= 1'b0;
         bus.timeout    <= 1'b0;
         for (int i = 0; i < N_LANES; i++)
            score[i] <= '0;
      end else begin
         state          <= state_n;
         done_q         <= bus.done;
         bus.start      <= start_n;
         bus.stop       <= stop_n;
         bus.lane_clr   <= clr_n;
         bus.winner_vld <= vld_n;
         bus.timeout    <= tout_n;
         if (state_n != state)
            timer <= '0;
         else if (state == ARM || state == PLAY)
            timer <= timer + 32'd1;
         if (win_entry) begin
            bus.winner <= pick_w;
            rr_ptr     <= next_lane(pick_w);
         end
         for (int i = 0; i < N_LANES; i++)
            if (win_entry && pick_w == i[1:0]
                && score[i] != SCORE_MAX)
               score[i] <= score[i] + 4'd1;
      end
   end

   assign bus.score0 = score[0];
   assign bus.score1 = score[1];
   assign bus.score2 = score[2];

   scan_tick #(
      .SCAN_DIV (SCAN_DIV)
   ) u_scan (
      .clock    (clock),
      .reset    (reset),
      .scan_sel (bus.scan_sel),
      .an       (bus.an)
   );

endmodule

// File: tb/tb_round_ctrl.sv
// Directed bench for round_ctrl: vector table for the round flow plus
// hand-written saturation, mid-round reset and display scan sequences.
module tb_round_ctrl;

   logic clk;
   logic rst;
   int   tests;
   int   failed;

   round_ctrl_if bus ();

   round_ctrl #(
      .ARM_CYCLES (16'd4),
      .TIMEOUT    (32'd20),
      .SCAN_DIV   (16'd3)
   ) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   typedef struct {
      logic        go;
      logic [2:0]  done;
      int          n;
      logic [24:0] exp;
   } vec_t;

   vec_t tbl [26];

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   function automatic logic [24:0] pk(
      input logic [2:0] st, sp, clr,
      input logic [1:0] w,
      input logic       v, to,
      input logic [3:0] s0, s1, s2
   );
      return {st, sp, clr, w, v, to, s0, s1, s2};
   endfunction

   function automatic vec_t mk(
      input logic go,
      input logic [2:0] d,
      input int n,
      input logic [24:0] e
   );
      vec_t r;
      r.go   = go;
      r.done = d;
      r.n    = n;
      r.exp  = e;
      return r;
   endfunction

   function automatic logic [24:0] obs();
      return {bus.start, bus.stop, bus.lane_clr,
              bus.winner, bus.winner_vld, bus.timeout,
              bus.score0, bus.score1, bus.score2};
   endfunction

   task automatic chk(
      input string nm,
      input logic [24:0] act,
      input logic [24:0] exp
   );
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      bus.go   = v.go;
      bus.done = v.done;
      @(negedge clk);
      bus.go = 1'b0;
      repeat (v.n - 1) @(negedge clk);
   endtask

   localparam logic [2:0] Z = 3'b000;
   localparam logic [2:0] F = 3'b111;

   initial begin
      logic [24:0] e;
      logic [3:0]  s0;
      logic [3:0]  one;
      logic [3:0]  ean;
      int          slot;

      clk      = 1'b0;
      rst      = 1'b1;
      tests    = 0;
      failed   = 0;
      bus.go   = 1'b0;
      bus.done = 3'b000;
      one      = 4'b0001;

      // round flow: arm, play, win, rotating ties, timeout, tie with timeout
      tbl[0]  = mk(1, Z, 1,  pk(Z, Z, F, 0, 0, 0, 0, 0, 0));
      tbl[1]  = mk(0, Z, 3,  pk(Z, Z, F, 0, 0, 0, 0, 0, 0));
      tbl[2]  = mk(0, Z, 1,  pk(F, Z, Z, 0, 0, 0, 0, 0, 0));
      tbl[3]  = mk(0, 3'b010, 1, pk(F, Z, Z, 0, 0, 0, 0, 0, 0));
      tbl[4]  = mk(0, 3'b010, 1, pk(F, F, Z, 1, 1, 0, 0, 1, 0));
      tbl[5]  = mk(1, Z, 1,  pk(Z, Z, F, 1, 0, 0, 0, 1, 0));
      tbl[6]  = mk(0, Z, 4,  pk(F, Z, Z, 1, 0, 0, 0, 1, 0));
      tbl[7]  = mk(0, F, 2,  pk(F, F, Z, 2, 1, 0, 0, 1, 1));
      tbl[8]  = mk(1, Z, 1,  pk(Z, Z, F, 2, 0, 0, 0, 1, 1));
      tbl[9]  = mk(0, Z, 4,  pk(F, Z, Z, 2, 0, 0, 0, 1, 1));
      tbl[10] = mk(0, F, 2,  pk(F, F, Z, 0, 1, 0, 1, 1, 1));
      tbl[11] = mk(1, Z, 1,  pk(Z, Z, F, 0, 0, 0, 1, 1, 1));
      tbl[12] = mk(0, Z, 4,  pk(F, Z, Z, 0, 0, 0, 1, 1, 1));
      tbl[13] = mk(0, F, 2,  pk(F, F, Z, 1, 1, 0, 1, 2, 1));
      tbl[14] = mk(1, Z, 1,  pk(Z, Z, F, 1, 0, 0, 1, 2, 1));
      tbl[15] = mk(0, Z, 4,  pk(F, Z, Z, 1, 0, 0, 1, 2, 1));
      tbl[16] = mk(0, F, 2,  pk(F, F, Z, 2, 1, 0, 1, 2, 2));
      tbl[17] = mk(1, Z, 1,  pk(Z, Z, F, 2, 0, 0, 1, 2, 2));
      tbl[18] = mk(0, Z, 4,  pk(F, Z, Z, 2, 0, 0, 1, 2, 2));
      tbl[19] = mk(0, Z, 19, pk(F, Z, Z, 2, 0, 0, 1, 2, 2));
      tbl[20] = mk(0, Z, 1,  pk(F, F, Z, 2, 0, 1, 1, 2, 2));
      tbl[21] = mk(1, Z, 1,  pk(Z, Z, F, 2, 0, 0, 1, 2, 2));
      tbl[22] = mk(0, Z, 4,  pk(F, Z, Z, 2, 0, 0, 1, 2, 2));
      tbl[23] = mk(0, Z, 18, pk(F, Z, Z, 2, 0, 0, 1, 2, 2));
      tbl[24] = mk(0, 3'b001, 1, pk(F, Z, Z, 2, 0, 0, 1, 2, 2));
      tbl[25] = mk(0, 3'b001, 1, pk(F, F, Z, 0, 1, 0, 2, 2, 2));

      @(negedge clk);
      @(negedge clk);
      chk("reset_outs", obs(), pk(Z, Z, F, 0, 0, 0, 0, 0, 0));
      chk("reset_scan", {23'd0, bus.scan_sel, bus.an},
          {23'd0, 2'd0, 4'b1110});
      rst = 1'b0;

      for (int i = 0; i < 26; i++) begin
         apply(tbl[i]);
         chk($sformatf("vec%0d", i), obs(), tbl[i].exp);
      end

      // lane 0 keeps winning until its score saturates
      s0 = 4'd2;
      for (int k = 1; k <= 14; k++) begin
         apply(mk(1, Z, 1, '0));
         apply(mk(0, Z, 4, '0));
         apply(mk(0, 3'b001, 2, '0));
         s0 = (s0 == 4'hF) ? 4'hF : s0 + 4'd1;
         e  = pk(F, F, Z, 0, 1, 0, s0, 2, 2);
         chk($sformatf("sat%0d", k), obs(), e);
      end

      // reset in the middle of PLAY
      apply(mk(1, Z, 1, '0));
      apply(mk(0, Z, 6, '0));
      chk("mid_play", obs(), pk(F, Z, Z, 0, 0, 0, 15, 2, 2));
      rst = 1'b1;
      @(negedge clk);
      chk("mid_reset", obs(), pk(Z, Z, F, 0, 0, 0, 0, 0, 0));

      // free-running display scan from reset
      for (int k = 0; k <= 9; k++) begin
         if (k == 1) rst = 1'b0;
         if (k > 0) @(negedge clk);
         slot = (k / 3) % 3;
         ean  = ~(one << slot);
         chk($sformatf("scan%0d", k),
             {19'd0, bus.scan_sel, bus.an},
             {19'd0, slot[1:0], ean});
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
